// File: rtl/gate_bist_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gate_bist_ctrl_pkg
// Shared definitions for the 2-input gate BIST controller and its settle timer:
// FSM state encoding, vector count, counter widths and a popcount helper.
// -----------------------------------------------------------------------------
package gate_bist_ctrl_pkg;

    localparam int NUM_VEC    = 4;  // all {a,b} combinations of a 2-input gate
    localparam int SETTLE_W   = 4;  // settle counter width, holds 0..15
    localparam int FAIL_CNT_W = 3;  // popcount of NUM_VEC bits, 0..4

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } bist_state_e;

    function automatic logic [FAIL_CNT_W-1:0] popcount_vec(input logic [NUM_VEC-1:0] v);
        logic [FAIL_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_VEC; i++) begin
            cnt = cnt + {{(FAIL_CNT_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gate_bist_ctrl_settle_timer.sv
// -----------------------------------------------------------------------------
// bist_settle_timer
// Loadable down-counter used to hold gate stimulus steady before sampling.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load_i      load value_i into the counter (has priority over dec_i)
//   value_i     load value
//   dec_i       decrement by one; saturates at zero
//   zero_o      counter currently equals zero
// -----------------------------------------------------------------------------
module bist_settle_timer
    import gate_bist_ctrl_pkg::*;
#(
    parameter int W = SETTLE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// gate_bist_ctrl
// Built-in self-test controller for a 2-input combinational gate. Drives the
// gate's a/b inputs through all four vectors, compares y against EXPECT_TT and
// reports per-vector failures, a failure count and an overall pass flag.
// Parameters:
//   EXPECT_TT      expected y per vector, bit index = {a,b} (AND = 4'b1000)
//   SETTLE_CYCLES  cycles a/b are held before y is sampled, 1..15
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   start          run request, honoured only when idle or showing results
//   dut_a, dut_b   registered stimulus to the gate
//   dut_y          gate response
//   busy           a run is in progress
//   done           results are valid (level)
//   pass           done and no vector failed
//   fail_vec       bit i set if vector i = {a,b} mismatched
//   fail_count     number of failing vectors
// -----------------------------------------------------------------------------
module gate_bist_ctrl
    import gate_bist_ctrl_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] EXPECT_TT     = 4'b1000,
    parameter int                 SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  dut_a,
    output logic                  dut_b,
    input  logic                  dut_y,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [NUM_VEC-1:0]    fail_vec,
    output logic [FAIL_CNT_W-1:0] fail_count
);

    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
        $error("gate_bist_ctrl: SETTLE_CYCLES=%0d outside 1..15", SETTLE_CYCLES);
    end

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    bist_state_e           state_q,      state_d;
    logic [1:0]            idx_q,        idx_d;
    logic                  dut_a_q,      dut_a_d;
    logic                  dut_b_q,      dut_b_d;
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;
    logic                  pass_q,       pass_d;
    logic [NUM_VEC-1:0]    fail_vec_q,   fail_vec_d;
    logic [FAIL_CNT_W-1:0] fail_count_q, fail_count_d;

    logic timer_load;
    logic timer_dec;
    logic timer_zero;
    logic accept;

    bist_settle_timer #(
        .W (SETTLE_W)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (timer_load),
        .value_i (SETTLE_LOAD),
        .dec_i   (timer_dec),
        .zero_o  (timer_zero)
    );

    // The first DONE cycle publishes the results; a restart is only taken
    // once done is visible, so a held start still shows every run's results.
    assign accept = start && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && done_q));

    // NOTE: every signal written here gets its default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dut_a_d      = dut_a_q;
        dut_b_d      = dut_b_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_vec_d   = fail_vec_q;
        fail_count_d = fail_count_q;
        timer_load   = 1'b0;
        timer_dec    = 1'b0;

        unique case (state_q)
            ST_IDLE: ;
            ST_APPLY: begin
                dut_a_d    = idx_q[1];
                dut_b_d    = idx_q[0];
                timer_load = 1'b1;
                state_d    = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (timer_zero) begin
                    state_d = ST_CHECK;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_CHECK: begin
                // Case inequality flags X/Z on y in simulation; synthesis
                // reduces it to an ordinary compare.
                if (dut_y !== EXPECT_TT[idx_q]) begin
                    fail_vec_d[idx_q] = 1'b1;
                end
                if (idx_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_APPLY;
                end
            end
            ST_DONE: begin
                if (!done_q) begin
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    pass_d       = (fail_vec_q == '0);
                    fail_count_d = popcount_vec(fail_vec_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d      = ST_APPLY;
            idx_d        = 2'd0;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            fail_vec_d   = '0;
            fail_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            dut_a_q      <= 1'b0;
            dut_b_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_vec_q   <= '0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dut_a_q      <= dut_a_d;
            dut_b_q      <= dut_b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_vec_q   <= fail_vec_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign dut_a      = dut_a_q;
    assign dut_b      = dut_b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_vec   = fail_vec_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_bist_ctrl
// Two controllers (AND expectation with 2 settle cycles, OR expectation with
// 1 settle cycle) each drive a behavioural gate whose truth table the bench
// chooses per run. Expected results come from comparing that truth table with
// the expected one; expected completion time from the run length formula.
// -----------------------------------------------------------------------------
module tb_gate_bist_ctrl;

    localparam logic [3:0] EXP0 = 4'b1000;
    localparam logic [3:0] EXP1 = 4'b1110;
    localparam int         S0   = 2;
    localparam int         S1   = 1;

    typedef struct {
        logic [3:0] fv;
        int         done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic       start0 = 1'b0, start1 = 1'b0;
    logic [3:0] tt0 = 4'b1000, tt1 = 4'b1110;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [3:0] fv0, fv1;
    logic [2:0] fc0, fc1;

    // Behavioural gates under test.
    assign y0 = tt0[{a0, b0}];
    assign y1 = tt1[{a1, b1}];

    gate_bist_ctrl #(.EXPECT_TT(EXP0), .SETTLE_CYCLES(S0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_a(a0), .dut_b(b0), .dut_y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_vec(fv0), .fail_count(fc0)
    );

    gate_bist_ctrl #(.EXPECT_TT(EXP1), .SETTLE_CYCLES(S1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_a(a1), .dut_b(b1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fv1), .fail_count(fc1)
    );

    exp_t q0[$];
    exp_t q1[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int run_len(input int s);
        return 1 + 4 * (s + 2);
    endfunction

    // Compare a completed run against the oldest expectation.
    task automatic score(input string tag, input exp_t e, input logic [3:0] fv,
                         input logic [2:0] fc, input logic ps, input logic bz,
                         input logic a, input logic b);
        check({tag, " done cycle"}, cyc, e.done_cyc);
        check({tag, " fail_vec"}, int'(fv), int'(e.fv));
        check({tag, " fail_count"}, int'(fc), $countones(e.fv));
        check({tag, " pass"}, int'(ps), int'(e.fv == 4'b0000));
        check({tag, " busy at done"}, int'(bz), 0);
        check({tag, " final a/b"}, int'({a, b}), 3);
    endtask

    task automatic unexpected(input string tag);
        checks++;
        errors++;
        $display("FAIL %s unexpected done at cycle %0d", tag, cyc);
    endtask

    // Monitors: pop an expectation on every rising edge of done.
    logic d0_prev = 1'b0, d1_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            d0_prev = 1'b0;
        end else begin
            if (done0 && !d0_prev) begin
                if (q0.size() == 0) unexpected("u0");
                else score("u0", q0.pop_front(), fv0, fc0, pass0, busy0, a0, b0);
            end
            d0_prev = done0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            d1_prev = 1'b0;
        end else begin
            if (done1 && !d1_prev) begin
                if (q1.size() == 0) unexpected("u1");
                else score("u1", q1.pop_front(), fv1, fc1, pass1, busy1, a1, b1);
            end
            d1_prev = done1;
        end
    end

    // Issue a one-cycle start to the selected controllers; returns the
    // acceptance edge number.
    task automatic start_run(input bit go0, input bit go1, input logic [3:0] t0,
                             input logic [3:0] t1, output int acc);
        exp_t e;
        @(negedge clk);
        acc = cyc + 1;
        if (go0) begin
            tt0 = t0;
            e.fv = t0 ^ EXP0;
            e.done_cyc = acc + run_len(S0);
            q0.push_back(e);
        end
        if (go1) begin
            tt1 = t1;
            e.fv = t1 ^ EXP1;
            e.done_cyc = acc + run_len(S1);
            q1.push_back(e);
        end
        start0 = go0;
        start1 = go1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for done: pending u0=%0d u1=%0d", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " u0 outputs"}, int'({a0, b0, busy0, done0, pass0, fv0, fc0}), 0);
        check({tag, " u1 outputs"}, int'({a1, b1, busy1, done1, pass1, fv1, fc1}), 0);
    endtask

    initial begin
        int acc;
        exp_t e;

        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Matching gates, y stuck at 0, y stuck at 1.
        start_run(1, 1, 4'b1000, 4'b1110, acc);
        wait_idle();
        start_run(1, 1, 4'b0000, 4'b0000, acc);
        wait_idle();
        start_run(1, 1, 4'b1111, 4'b1111, acc);
        wait_idle();

        // Random truth tables.
        for (int i = 0; i < 12; i++) begin
            start_run(1, 1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), acc);
            wait_idle();
        end

        // start re-pulsed while busy must not disturb the running test.
        start_run(1, 1, 4'b1000, 4'b1110, acc);
        repeat (3) @(negedge clk);
        check("busy before repulse", int'({busy0, busy1}), 3);
        start0 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        wait_idle();

        // start held high in DONE: each run completes and the next starts.
        begin
            int  seen = 0;
            int  n = 0;
            bit  prev = 1'b1;
            @(negedge clk);
            tt0 = 4'b1000;
            e.fv = 4'b0000;
            e.done_cyc = cyc + 1 + run_len(S0);
            q0.push_back(e);
            start0 = 1'b1;
            while (seen < 2 && n < 200) begin
                @(negedge clk);
                n++;
                if (done0 && !prev) begin
                    seen++;
                    if (seen == 1) begin
                        e.done_cyc = cyc + 1 + run_len(S0);
                        q0.push_back(e);
                    end
                end
                prev = done0;
                if (seen == 1 && done0 == 1'b0 && prev == 1'b0 && busy0 && n < 200
                    && cyc == e.done_cyc - run_len(S0)) begin
                    check("restart clears done", int'({done0, busy0}), 1);
                end
            end
            start0 = 1'b0;
            if (seen < 2) begin
                checks++;
                errors++;
                $display("FAIL held start: saw %0d of 2 runs", seen);
            end
            wait_idle();
        end

        // Reset during SETTLE of vector 2 of a failing run.
        start_run(1, 1, 4'b0111, 4'b0001, acc);
        while (cyc != acc + 9) @(negedge clk);
        check("u0 partial fail_vec", int'(fv0), 3);
        #1 rst_n = 1'b0;
        #1 check_all_zero("mid-run reset");
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start_run(1, 1, 4'b1000, 4'b1110, acc);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
